// File: rtl/ir_multiword.sv
// rtl/ir_multiword.sv - multi-word instruction register for the SAP W-bus
// Optional even-parity check on loaded words when IR_PARITY_EN is defined.
module ir_multiword #(
  parameter int DATA_W  = 8,
  parameter int OPC_W   = 4,
  parameter int MAX_EXT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              li_n,
  input  logic              ei_n,
  input  logic              clr,
  input  logic [1:0]        opsel,
  input  logic [DATA_W-1:0] wbus,
`ifdef IR_PARITY_EN
  input  logic              wbus_par,
  output logic              par_err,
`endif
  output logic [OPC_W-1:0]  opcode,
  output logic              ir_valid,
  output logic              busy,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe
);

  localparam int OPR_W = DATA_W - OPC_W;
  localparam logic [1:0] MAX_N = 2'(MAX_EXT);

  typedef enum logic [1:0] {IDLE, FETCH_EXT, READY} state_t;

  state_t              state_q;
  logic [OPC_W-1:0]    opcode_q;
  logic [OPR_W-1:0]    inline_q;
  logic [DATA_W-1:0]   ext_q [MAX_EXT];
  logic [1:0]          n_q, cnt_q;
  logic                ir_valid_q, busy_q, bus_oe_q;
  logic [DATA_W-1:0]   bus_out_q;
  logic [1:0]          n_raw, n_d;
  logic [DATA_W-1:0]   sel_d;
`ifdef IR_PARITY_EN
  logic                par_err_q;
`endif

  // Length field overlaps the opcode's top bits; clamp to what we can hold.
  always_comb begin
    n_raw = wbus[DATA_W-1 -: 2];
    n_d   = (n_raw > MAX_N) ? MAX_N : n_raw;
  end

  always_comb begin
    sel_d = '0;
    if (opsel <= n_q) begin
      if (opsel == 2'd0) begin
        sel_d = DATA_W'(inline_q);
      end
      for (int i = 0; i < MAX_EXT; i++) begin
        if (opsel == 2'(i + 1)) sel_d = ext_q[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      opcode_q   <= '0;
      inline_q   <= '0;
      for (int i = 0; i < MAX_EXT; i++) ext_q[i] <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      bus_oe_q   <= 1'b0;
      bus_out_q  <= '0;
`ifdef IR_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else if (clr) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      bus_oe_q   <= 1'b0;
      bus_out_q  <= '0;
`ifdef IR_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      bus_oe_q  <= 1'b0;
      bus_out_q <= '0;
`ifdef IR_PARITY_EN
      if (!li_n && ((^wbus) != wbus_par)) par_err_q <= 1'b1;
`endif
      case (state_q)
        FETCH_EXT: begin
          if (!li_n) begin
            for (int i = 0; i < MAX_EXT; i++) begin
              if (cnt_q == 2'(i)) ext_q[i] <= wbus;
            end
            cnt_q <= cnt_q + 2'd1;
            if (2'(cnt_q + 2'd1) == n_q) begin
              state_q    <= READY;
              busy_q     <= 1'b0;
              ir_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          if (!li_n) begin
            opcode_q <= wbus[DATA_W-1 -: OPC_W];
            inline_q <= wbus[OPR_W-1:0];
            for (int i = 0; i < MAX_EXT; i++) ext_q[i] <= '0;
            n_q      <= n_d;
            cnt_q    <= '0;
            if (n_d == 2'd0) begin
              state_q    <= READY;
              ir_valid_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              state_q    <= FETCH_EXT;
              ir_valid_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end else if (state_q == READY && !ei_n) begin
            bus_oe_q  <= 1'b1;
            bus_out_q <= sel_d;
          end
        end
      endcase
    end
  end

  assign opcode   = opcode_q;
  assign ir_valid = ir_valid_q;
  assign busy     = busy_q;
  assign bus_out  = bus_out_q;
  assign bus_oe   = bus_oe_q;
`ifdef IR_PARITY_EN
  assign par_err  = par_err_q;
`endif

endmodule

// File: tb/tb_ir_multiword.sv
// tb/tb_ir_multiword.sv - directed self-checking bench for ir_multiword
// Covers parity checks too when IR_PARITY_EN is defined.
module tb_ir_multiword;

  logic       clock = 1'b0;
  logic       reset, li_n, ei_n, clr;
  logic [1:0] opsel;
  logic [7:0] wbus;
  logic [3:0] opcode;
  logic       ir_valid, busy, bus_oe;
  logic [7:0] bus_out;
`ifdef IR_PARITY_EN
  logic       wbus_par, par_err;
`endif

  int total = 0;
  int bad   = 0;

  ir_multiword dut (
    .clock    (clock),
    .reset    (reset),
    .li_n     (li_n),
    .ei_n     (ei_n),
    .clr      (clr),
    .opsel    (opsel),
    .wbus     (wbus),
`ifdef IR_PARITY_EN
    .wbus_par (wbus_par),
    .par_err  (par_err),
`endif
    .opcode   (opcode),
    .ir_valid (ir_valid),
    .busy     (busy),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_word(input logic [7:0] w);
    wbus = w;
`ifdef IR_PARITY_EN
    wbus_par = ^w;
`endif
  endtask

  task automatic load(input logic [7:0] w);
    li_n = 1'b0;
    drive_word(w);
    tick();
    li_n = 1'b1;
  endtask

  task automatic read_op(input logic [1:0] sel);
    ei_n  = 1'b0;
    opsel = sel;
    tick();
    ei_n  = 1'b1;
  endtask

  initial begin
    reset = 1'b1; li_n = 1'b1; ei_n = 1'b1; clr = 1'b0; opsel = 2'd0;
    drive_word(8'h00);
    tick(); tick();
    reset = 1'b0;
    check("rst_opcode", 32'(opcode), 32'h0);
    check("rst_valid", 32'(ir_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_oe", 32'(bus_oe), 32'h0);
    check("rst_out", 32'(bus_out), 32'h0);
`ifdef IR_PARITY_EN
    check("rst_par", 32'(par_err), 32'h0);
`endif

    // single-word instruction
    load(8'h3A);
    check("s1_opcode", 32'(opcode), 32'h3);
    check("s1_valid", 32'(ir_valid), 32'h1);
    check("s1_busy", 32'(busy), 32'h0);
    check("s1_oe_idle", 32'(bus_oe), 32'h0);
    read_op(2'd0);
    check("s1_oe", 32'(bus_oe), 32'h1);
    check("s1_out", 32'(bus_out), 32'h0A);
    tick();
    check("s1_oe_off", 32'(bus_oe), 32'h0);
    check("s1_out_off", 32'(bus_out), 32'h0);

    // two extension words, load started from READY
    load(8'h85);
    check("s2_busy1", 32'(busy), 32'h1);
    check("s2_valid1", 32'(ir_valid), 32'h0);
    load(8'h12);
    check("s2_busy2", 32'(busy), 32'h1);
    load(8'h34);
    check("s2_valid", 32'(ir_valid), 32'h1);
    check("s2_busy", 32'(busy), 32'h0);
    check("s2_opcode", 32'(opcode), 32'h8);
    read_op(2'd1);
    check("s2_op1", 32'(bus_out), 32'h12);
    read_op(2'd2);
    check("s2_op2", 32'(bus_out), 32'h34);
    read_op(2'd0);
    check("s2_op0", 32'(bus_out), 32'h05);
    check("s2_op0_oe", 32'(bus_oe), 32'h1);

    // N=3 clamped to 2, with a stall and a read attempt mid-fetch
    load(8'hC1);
    load(8'h55);
    read_op(2'd1);
    check("s3_stall_busy", 32'(busy), 32'h1);
    check("s3_stall_oe", 32'(bus_oe), 32'h0);
    check("s3_stall_valid", 32'(ir_valid), 32'h0);
    load(8'h66);
    check("s3_valid", 32'(ir_valid), 32'h1);
    check("s3_busy", 32'(busy), 32'h0);
    check("s3_opcode", 32'(opcode), 32'hC);
    read_op(2'd3);
    check("s3_op3", 32'(bus_out), 32'h00);
    check("s3_op3_oe", 32'(bus_oe), 32'h1);
    read_op(2'd1);
    check("s3_op1", 32'(bus_out), 32'h55);
    read_op(2'd2);
    check("s3_op2", 32'(bus_out), 32'h66);

    // load and enable together: load wins
    li_n = 1'b0; ei_n = 1'b0; opsel = 2'd0;
    drive_word(8'h3F);
    tick();
    li_n = 1'b1; ei_n = 1'b1;
    check("s4_oe", 32'(bus_oe), 32'h0);
    check("s4_opcode", 32'(opcode), 32'h3);
    check("s4_valid", 32'(ir_valid), 32'h1);
    clr = 1'b1; ei_n = 1'b0;
    tick();
    clr = 1'b0;
    check("s4_clr_valid", 32'(ir_valid), 32'h0);
    check("s4_clr_opcode", 32'(opcode), 32'h3);
    check("s4_clr_oe", 32'(bus_oe), 32'h0);
    tick();
    ei_n = 1'b1;
    check("s4_idle_oe", 32'(bus_oe), 32'h0);

    // reset mid-fetch discards the partial instruction
    load(8'h85);
    load(8'h12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s5_opcode", 32'(opcode), 32'h0);
    check("s5_valid", 32'(ir_valid), 32'h0);
    check("s5_busy", 32'(busy), 32'h0);
    check("s5_oe", 32'(bus_oe), 32'h0);
    check("s5_out", 32'(bus_out), 32'h0);
    load(8'h3A);
    check("s5_opcode2", 32'(opcode), 32'h3);
    check("s5_valid2", 32'(ir_valid), 32'h1);
    read_op(2'd0);
    check("s5_out2", 32'(bus_out), 32'h0A);
    read_op(2'd1);
    check("s5_sel_gt_n", 32'(bus_out), 32'h00);

`ifdef IR_PARITY_EN
    li_n = 1'b0; wbus = 8'h3A; wbus_par = 1'b1;
    tick();
    li_n = 1'b1;
    check("s6_par", 32'(par_err), 32'h1);
    check("s6_opcode", 32'(opcode), 32'h3);
    load(8'h11);
    check("s6_par_sticky", 32'(par_err), 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("s6_par_clr", 32'(par_err), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_multiword.md
Name: ir_multiword

Overview:
- Parametrised instruction register for the SAP-class CPU, sitting on the shared W-bus.
- Captures a one-word opcode/operand instruction from the bus, then zero to MAX_EXT extension operand words, as a small FSM.
- Presents the opcode to the controller-sequencer and drives a selected operand back onto the bus on request.
- Generalises the fixed 8-bit, single-word IR to configurable width, opcode split and multi-word instructions.

Parameters:
- DATA_W, 8: bus and instruction word width.
- OPC_W, 4: opcode field width, taken from word0 [DATA_W-1 -: OPC_W]. Range 2..DATA_W-1.
- MAX_EXT, 2: maximum number of extension operand words. Range 1..3.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- li_n  in  1  active-low load: capture wbus this edge.
- ei_n  in  1  active-low enable: drive the selected operand onto the bus.
- clr  in  1  synchronous abort; FSM returns to IDLE.
- opsel  in  2  operand select: 0 = inline field, 1..MAX_EXT = extension word.
- wbus  in  DATA_W  W-bus input.
- opcode  out  OPC_W  registered opcode.
- ir_valid  out  1  complete instruction held.
- busy  out  1  extension words still pending.
- bus_out  out  DATA_W  operand data for the bus.
- bus_oe  out  1  bus_out valid; bus mux qualifier.

Behaviour:
- Single clock domain, clock. reset is synchronous and active-high, and has highest priority.
- Reset values: opcode=0, ir_valid=0, busy=0, bus_out=0, bus_oe=0, ext counter=0, all operand registers 0, state=IDLE.
- All outputs are registered. Each takes effect one edge after its input is sampled.
- Priority per edge: reset > clr > li_n load > ei_n drive.
- Length field: the top 2 bits of word0 give the extension count N. If N > MAX_EXT, N is clamped to MAX_EXT.
- IDLE, li_n=0:
  - Capture word0 into opcode and the inline operand (low DATA_W-OPC_W bits, zero-extended).
  - Clear all extension registers.
  - If N=0, go to READY (ir_valid=1). Otherwise go to FETCH_EXT (busy=1, ext counter=0).
- FETCH_EXT, li_n=0: store wbus into ext[counter] and increment the counter. When counter reaches N, go to READY (busy=0, ir_valid=1).
- FETCH_EXT, li_n=1: hold all state.
- READY: ir_valid=1.
  - li_n=0 starts a new capture exactly as in IDLE. ir_valid drops to 0 if the new N>0; it stays 1 if N=0.
- ei_n handling:
  - ei_n=0 sampled in READY with li_n=1: bus_oe=1, bus_out=operand[opsel].
  - opsel > N: bus_out=0.
  - ei_n=1, any non-READY state, or simultaneous li_n=0: bus_oe=0, bus_out=0.
- clr: forces IDLE next edge. ir_valid=0, busy=0, bus_oe=0, bus_out=0. opcode and operand registers are held.
- Reset mid-FETCH_EXT: the partial instruction is discarded and every reset value is applied.
- ei_n is ignored while reset or clr is asserted.

Optional Feature:
- Macro: IR_PARITY_EN.
- With the macro defined:
  - Adds input wbus_par (1 bit, even parity over wbus) and output par_err (1 bit).
  - Any load edge where ^wbus != wbus_par sets par_err.
  - par_err is sticky until reset or clr. It does not block the capture.
- Without the macro: neither port exists, and no parity logic is built.

Test Plan:
(All scenarios use default parameters: DATA_W=8, OPC_W=4, MAX_EXT=2.)
1. Reset, load 0x3A, then ei_n=0 with opsel=0 -> opcode=0x3, ir_valid=1 one edge after load, busy=0; next edge bus_oe=1, bus_out=0x0A.
2. Load 0x85, 0x12, 0x34 on consecutive edges -> busy=1 after the first load; ir_valid=1 and opcode=0x8 after the third. opsel=1 gives bus_out=0x12, opsel=2 gives 0x34.
3. Load 0xC1, 0x55, 0x66 (N=3 clamped to 2) -> ir_valid=1 after 0x66, busy=0. opsel=3 gives bus_out=0x00.
4. In READY, li_n=0 and ei_n=0 on the same edge with wbus=0x3F -> bus_oe=0, opcode=0x3, ir_valid=1. Then clr=1 -> ir_valid=0, opcode still 0x3.
5. Load 0x85, 0x12, then reset=1 -> all outputs 0, state IDLE. Then load 0x3A -> same response as scenario 1.
6. With IR_PARITY_EN: load 0x3A with wbus_par=1 -> par_err=1 and opcode=0x3. par_err stays 1 until clr=1, then reads 0.
